// File: rtl/reg_wb_scoreboard_if.sv
// Issue, write-back and register-file signals of the write-back scoreboard.
// The master side is the pipeline/bench and the slave side is reg_wb_scoreboard.
interface reg_wb_scoreboard_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic                   issue_valid;
    logic [REG_AW-1:0]      issue_rs1;
    logic [REG_AW-1:0]      issue_rs2;
    logic [REG_AW-1:0]      issue_rd;
    logic                   issue_rd_we;
    logic                   issue_long;
    logic                   issue_stall;
    logic                   alu_wb_valid;
    logic [REG_AW-1:0]      alu_wb_rd;
    logic [XLEN-1:0]        alu_wb_data;
    logic                   lsu_wb_valid;
    logic [REG_AW-1:0]      lsu_wb_rd;
    logic [XLEN-1:0]        lsu_wb_data;
    logic                   lsu_wb_ready;
    logic                   rf_we;
    logic [REG_AW-1:0]      rf_waddr;
    logic [XLEN-1:0]        rf_wdata;
    logic [2**REG_AW-1:0]   busy_mask;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we, issue_long,
        output alu_wb_valid, alu_wb_rd, alu_wb_data,
        output lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        input  issue_stall, lsu_wb_ready, rf_we, rf_waddr, rf_wdata, busy_mask
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_rd, issue_rd_we, issue_long,
        input  alu_wb_valid, alu_wb_rd, alu_wb_data,
        input  lsu_wb_valid, lsu_wb_rd, lsu_wb_data,
        output issue_stall, lsu_wb_ready, rf_we, rf_waddr, rf_wdata, busy_mask
    );
endinterface

// File: rtl/reg_wb_scoreboard.sv
// Write-back arbiter (ALU over buffered LSU) with a long-latency hazard scoreboard.
// Define LSU_BYPASS_EN to let an LSU result skip an empty buffer when the ALU is idle.
module reg_wb_scoreboard #(
    parameter int XLEN     = 32,
    parameter int REG_AW   = 5,
    parameter int LQ_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    reg_wb_scoreboard_if.slave  bus
);
    localparam int NREG = 2**REG_AW;
    localparam int PW   = $clog2(LQ_DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(LQ_DEPTH);

    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   clr_vec;
    logic [NREG-1:0]   set_vec;
    logic [NREG-1:0]   busy_eff;
    logic [NREG-1:0]   busy_nxt;
    logic [REG_AW-1:0] q_rd   [LQ_DEPTH];
    logic [XLEN-1:0]   q_data [LQ_DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW:0]       count;
    logic              rf_long;
    logic              lsu_xfer;
    logic              lsu_nz;
    logic              alu_win;
    logic              q_empty;
    logic              bypass;
    logic              pop;
    logic              push;

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        // A long write on the port this cycle lands at negedge, so it no longer blocks issue.
        if (bus.rf_we && rf_long) clr_vec[bus.rf_waddr] = 1'b1;
        busy_eff = busy & ~clr_vec;
        bus.issue_stall = bus.issue_valid &
                          (busy_eff[bus.issue_rs1] | busy_eff[bus.issue_rs2] |
                           (bus.issue_rd_we & busy_eff[bus.issue_rd]));
        bus.lsu_wb_ready = (count != FULL_CNT);
        lsu_xfer = bus.lsu_wb_valid & bus.lsu_wb_ready;
        lsu_nz   = (bus.lsu_wb_rd != '0);
        alu_win  = bus.alu_wb_valid & (bus.alu_wb_rd != '0);
        q_empty  = (count == '0);
`ifdef LSU_BYPASS_EN
        bypass   = ~alu_win & q_empty & lsu_xfer & lsu_nz;
`else
        bypass   = 1'b0;
`endif
        pop  = ~alu_win & ~q_empty;
        push = lsu_xfer & lsu_nz & ~bypass;
        if (bus.issue_valid && !bus.issue_stall && bus.issue_rd_we && bus.issue_long &&
            bus.issue_rd != '0)
            set_vec[bus.issue_rd] = 1'b1;
        busy_nxt    = busy_eff | set_vec;
        busy_nxt[0] = 1'b0;
    end

    assign bus.busy_mask = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy         <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            rf_long      <= 1'b0;
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
        end else begin
            busy    <= busy_nxt;
            count   <= count + (PW+1)'(push) - (PW+1)'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            bus.rf_we <= alu_win | pop | bypass;
            rf_long   <= ~alu_win & (pop | bypass);
            if (alu_win) begin
                bus.rf_waddr <= bus.alu_wb_rd;
                bus.rf_wdata <= bus.alu_wb_data;
            end else if (pop) begin
                bus.rf_waddr <= q_rd[rd_ptr];
                bus.rf_wdata <= q_data[rd_ptr];
            end else if (bypass) begin
                bus.rf_waddr <= bus.lsu_wb_rd;
                bus.rf_wdata <= bus.lsu_wb_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= bus.lsu_wb_rd;
            q_data[wr_ptr] <= bus.lsu_wb_data;
        end
    end
endmodule

// File: tb/tb_reg_wb_scoreboard.sv
// Directed scenarios plus a randomized run against a queue-based write-back model.
module tb_reg_wb_scoreboard;
    localparam int XLEN = 32, REG_AW = 5, LQ_DEPTH = 4;
`ifdef LSU_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_wb_scoreboard_if #(.XLEN(XLEN), .REG_AW(REG_AW)) bif();
    reg_wb_scoreboard #(.XLEN(XLEN), .REG_AW(REG_AW), .LQ_DEPTH(LQ_DEPTH)) dut (
        .clk(clk), .rst(rst), .bus(bif)
    );

    typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;
    wb_t         m_q[$];
    logic [31:0] m_busy;
    logic        m_we, m_lsu;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bif.issue_valid = 0; bif.issue_rs1 = 0; bif.issue_rs2 = 0; bif.issue_rd = 0;
        bif.issue_rd_we = 0; bif.issue_long = 0;
        bif.alu_wb_valid = 0; bif.alu_wb_rd = 0; bif.alu_wb_data = 0;
        bif.lsu_wb_valid = 0; bif.lsu_wb_rd = 0; bif.lsu_wb_data = 0;
    endtask

    task automatic model_reset();
        m_q.delete();
        m_busy = 0; m_we = 0; m_lsu = 0; m_waddr = 0; m_wdata = 0;
    endtask

    // A register blocks issue while pending, unless its long result is on the port now.
    function automatic logic m_blocked(input logic [4:0] r);
        return (r != 0) && m_busy[r] && !(m_we && m_lsu && m_waddr == r);
    endfunction

    function automatic logic m_stall();
        return bif.issue_valid && (m_blocked(bif.issue_rs1) || m_blocked(bif.issue_rs2) ||
                                   (bif.issue_rd_we && m_blocked(bif.issue_rd)));
    endfunction

    function automatic logic m_ready();
        return m_q.size() < LQ_DEPTH;
    endfunction

    task automatic model_advance();
        logic acc, xfer;
        logic [31:0] nb;
        wb_t h;
        acc  = bif.issue_valid && !m_stall();
        xfer = bif.lsu_wb_valid && m_ready();
        nb   = m_busy;
        if (m_we && m_lsu) nb[m_waddr] = 1'b0;
        if (acc && bif.issue_rd_we && bif.issue_long && bif.issue_rd != 0) nb[bif.issue_rd] = 1'b1;
        if (bif.alu_wb_valid && bif.alu_wb_rd != 0) begin
            m_we = 1; m_lsu = 0; m_waddr = bif.alu_wb_rd; m_wdata = bif.alu_wb_data;
        end else if (m_q.size() > 0) begin
            h = m_q.pop_front();
            m_we = 1; m_lsu = 1; m_waddr = h.rd; m_wdata = h.data;
        end else if (BYPASS && xfer && bif.lsu_wb_rd != 0) begin
            m_we = 1; m_lsu = 1; m_waddr = bif.lsu_wb_rd; m_wdata = bif.lsu_wb_data;
            xfer = 0;
        end else begin
            m_we = 0; m_lsu = 0;
        end
        if (xfer && bif.lsu_wb_rd != 0) begin
            h.rd = bif.lsu_wb_rd; h.data = bif.lsu_wb_data;
            m_q.push_back(h);
        end
        m_busy = nb;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick(); tick();
        bif.issue_valid = 1; bif.issue_rs1 = 5; bif.issue_rs2 = 6;
        #1;
        checks++; if (bif.rf_we !== 1'b0) begin errors++; $display("FAIL reset_rf_we: got %b expected 0", bif.rf_we); end
        checks++; if (bif.rf_waddr !== 5'd0) begin errors++; $display("FAIL reset_rf_waddr: got %0d expected 0", bif.rf_waddr); end
        checks++; if (bif.rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_rf_wdata: got %h expected 0", bif.rf_wdata); end
        checks++; if (bif.busy_mask !== 32'd0) begin errors++; $display("FAIL reset_busy: got %h expected 0", bif.busy_mask); end
        checks++; if (bif.lsu_wb_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bif.lsu_wb_ready); end
        checks++; if (bif.issue_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", bif.issue_stall); end
        idle_inputs();
        tick();
        rst = 0;
        // Mid-stream: ALU keeps the port busy so three LSU results stay buffered.
        bif.issue_valid = 1; bif.issue_rd = 10; bif.issue_rd_we = 1; bif.issue_long = 1;
        for (int k = 0; k < 3; k++) begin
            bif.alu_wb_valid = 1; bif.alu_wb_rd = 1; bif.alu_wb_data = 32'h55 + k;
            bif.lsu_wb_valid = 1; bif.lsu_wb_rd = 5'(11 + k); bif.lsu_wb_data = 32'hA0 + k;
            tick();
            bif.issue_valid = 0;
        end
        #1;
        rst = 1;
        #1;
        checks++; if (bif.rf_we !== 1'b0) begin errors++; $display("FAIL midreset_rf_we: got %b expected 0", bif.rf_we); end
        checks++; if (bif.busy_mask !== 32'd0) begin errors++; $display("FAIL midreset_busy: got %h expected 0", bif.busy_mask); end
        checks++; if (bif.lsu_wb_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b expected 1", bif.lsu_wb_ready); end
        idle_inputs();
        tick();
        rst = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (bif.rf_we !== 1'b0) begin errors++; $display("FAIL stale_write: cycle %0d got rf_we %b addr %0d expected 0", k, bif.rf_we, bif.rf_waddr); end
        end
    endtask

    task automatic test_raw_hazard();
        bit found;
        idle_inputs();
        bif.issue_valid = 1; bif.issue_rd = 5; bif.issue_rd_we = 1; bif.issue_long = 1;
        #1;
        checks++; if (bif.issue_stall !== 1'b0) begin errors++; $display("FAIL raw_load_issue: got stall %b expected 0", bif.issue_stall); end
        tick();
        bif.issue_rs1 = 5; bif.issue_rs2 = 1; bif.issue_rd = 6; bif.issue_long = 0;
        #1;
        checks++; if (bif.busy_mask[5] !== 1'b1) begin errors++; $display("FAIL raw_busy_set: got %b expected 1", bif.busy_mask[5]); end
        for (int k = 0; k < 2; k++) begin
            checks++; if (bif.issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall: cycle %0d got %b expected 1", k, bif.issue_stall); end
            tick();
        end
        bif.lsu_wb_valid = 1; bif.lsu_wb_rd = 5; bif.lsu_wb_data = 32'hDEADBEEF;
        #1;
        checks++; if (bif.lsu_wb_ready !== 1'b1) begin errors++; $display("FAIL raw_lsu_ready: got %b expected 1", bif.lsu_wb_ready); end
        tick();
        bif.lsu_wb_valid = 0;
        found = 0;
        for (int k = 0; k < 8 && !found; k++) begin
            #1;
            if (bif.rf_we === 1'b1 && bif.rf_waddr === 5'd5) found = 1;
            else begin
                checks++; if (bif.issue_stall !== 1'b1) begin errors++; $display("FAIL raw_stall_wait: got %b expected 1", bif.issue_stall); end
                tick();
            end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL raw_wb_timeout: got no write to x5 expected one within 8 cycles");
        end else begin
            checks++; if (bif.rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL raw_wb_data: got %h expected deadbeef", bif.rf_wdata); end
            checks++; if (bif.issue_stall !== 1'b0) begin errors++; $display("FAIL raw_unstall: got %b expected 0", bif.issue_stall); end
            checks++; if (bif.busy_mask[5] !== 1'b1) begin errors++; $display("FAIL raw_busy_hold: got %b expected 1", bif.busy_mask[5]); end
        end
        tick();
        idle_inputs();
        checks++; if (bif.busy_mask[5] !== 1'b0) begin errors++; $display("FAIL raw_busy_clear: got %b expected 0", bif.busy_mask[5]); end
        tick(); tick();
    endtask

    task automatic test_conflict();
        idle_inputs();
        bif.alu_wb_valid = 1; bif.alu_wb_rd = 7; bif.alu_wb_data = 32'h11;
        bif.lsu_wb_valid = 1; bif.lsu_wb_rd = 8; bif.lsu_wb_data = 32'h22;
        tick();
        idle_inputs();
        checks++; if (bif.rf_we !== 1'b1 || bif.rf_waddr !== 5'd7 || bif.rf_wdata !== 32'h11) begin
            errors++; $display("FAIL conflict_alu: got we %b x%0d=%h expected 1 x7=00000011", bif.rf_we, bif.rf_waddr, bif.rf_wdata); end
        tick();
        checks++; if (bif.rf_we !== 1'b1 || bif.rf_waddr !== 5'd8 || bif.rf_wdata !== 32'h22) begin
            errors++; $display("FAIL conflict_lsu: got we %b x%0d=%h expected 1 x8=00000022", bif.rf_we, bif.rf_waddr, bif.rf_wdata); end
        tick();
        checks++; if (bif.rf_we !== 1'b0) begin errors++; $display("FAIL conflict_idle: got %b expected 0", bif.rf_we); end
    endtask

    task automatic test_back_pressure();
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            bif.alu_wb_valid = 1; bif.alu_wb_rd = 3; bif.alu_wb_data = 32'(k);
            bif.lsu_wb_valid = 1; bif.lsu_wb_rd = 5'(20 + k); bif.lsu_wb_data = 32'h100 + k;
            #1;
            checks++; if (bif.lsu_wb_ready !== (k < 4)) begin errors++; $display("FAIL bp_ready: offer %0d got %b expected %b", k, bif.lsu_wb_ready, (k < 4)); end
            tick();
        end
        idle_inputs();
        tick();
        for (int j = 0; j < 4; j++) begin
            checks++; if (bif.rf_we !== 1'b1 || bif.rf_waddr !== 5'(20 + j) || bif.rf_wdata !== 32'h100 + j) begin
                errors++; $display("FAIL bp_drain: entry %0d got we %b x%0d=%h expected 1 x%0d=%h", j, bif.rf_we, bif.rf_waddr, bif.rf_wdata, 20 + j, 32'h100 + j); end
            tick();
        end
        checks++; if (bif.rf_we !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", bif.rf_we); end
        checks++; if (bif.lsu_wb_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b expected 1", bif.lsu_wb_ready); end
    endtask

    task automatic test_zero_reg();
        idle_inputs();
        bif.issue_valid = 1; bif.issue_rd = 0; bif.issue_rd_we = 1; bif.issue_long = 1;
        bif.alu_wb_valid = 1; bif.alu_wb_rd = 0; bif.alu_wb_data = 32'hFFFF;
        bif.lsu_wb_valid = 1; bif.lsu_wb_rd = 0; bif.lsu_wb_data = 32'hEEEE;
        #1;
        checks++; if (bif.issue_stall !== 1'b0) begin errors++; $display("FAIL zero_stall: got %b expected 0", bif.issue_stall); end
        checks++; if (bif.lsu_wb_ready !== 1'b1) begin errors++; $display("FAIL zero_ready: got %b expected 1", bif.lsu_wb_ready); end
        tick();
        idle_inputs();
        checks++; if (bif.busy_mask !== 32'd0) begin errors++; $display("FAIL zero_busy: got %h expected 0", bif.busy_mask); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (bif.rf_we !== 1'b0) begin errors++; $display("FAIL zero_write: cycle %0d got %b expected 0", k, bif.rf_we); end
            tick();
        end
    endtask

    task automatic test_waw();
        idle_inputs();
        bif.issue_valid = 1; bif.issue_rd = 9; bif.issue_rd_we = 1; bif.issue_long = 1;
        tick();
        bif.issue_rs1 = 1; bif.issue_rs2 = 2; bif.issue_long = 0;
        #1;
        checks++; if (bif.busy_mask[9] !== 1'b1) begin errors++; $display("FAIL waw_busy: got %b expected 1", bif.busy_mask[9]); end
        for (int k = 0; k < 3; k++) begin
            checks++; if (bif.issue_stall !== 1'b1) begin errors++; $display("FAIL waw_stall: cycle %0d got %b expected 1", k, bif.issue_stall); end
            tick();
        end
        bif.lsu_wb_valid = 1; bif.lsu_wb_rd = 9; bif.lsu_wb_data = 32'h99;
        tick();
        bif.lsu_wb_valid = 0;
        if (!BYPASS) begin
            checks++; if (bif.rf_we !== 1'b0 || bif.issue_stall !== 1'b1) begin
                errors++; $display("FAIL waw_buffered: got we %b stall %b expected we 0 stall 1", bif.rf_we, bif.issue_stall); end
            tick();
        end
        checks++; if (bif.rf_we !== 1'b1 || bif.rf_waddr !== 5'd9 || bif.rf_wdata !== 32'h99) begin
            errors++; $display("FAIL waw_write: got we %b x%0d=%h expected 1 x9=00000099", bif.rf_we, bif.rf_waddr, bif.rf_wdata); end
        checks++; if (bif.issue_stall !== 1'b0) begin errors++; $display("FAIL waw_unstall: got %b expected 0", bif.issue_stall); end
        tick();
        idle_inputs();
        checks++; if (bif.busy_mask[9] !== 1'b0) begin errors++; $display("FAIL waw_busy_clear: got %b expected 0", bif.busy_mask[9]); end
    endtask

    task automatic test_random();
        logic exp_stall, exp_ready;
        idle_inputs();
        rst = 1;
        tick();
        model_reset();
        rst = 0;
        for (int c = 0; c < 800; c++) begin
            bif.issue_valid  = ($urandom_range(0, 1) == 1);
            bif.issue_rs1    = 5'($urandom_range(0, 7));
            bif.issue_rs2    = 5'($urandom_range(0, 7));
            bif.issue_rd     = 5'($urandom_range(0, 7));
            bif.issue_rd_we  = ($urandom_range(0, 3) != 0);
            bif.issue_long   = ($urandom_range(0, 2) == 0);
            bif.alu_wb_valid = ($urandom_range(0, 2) == 0);
            bif.alu_wb_rd    = 5'($urandom_range(0, 7));
            bif.alu_wb_data  = $urandom;
            bif.lsu_wb_valid = ($urandom_range(0, 1) == 1);
            bif.lsu_wb_rd    = 5'($urandom_range(0, 7));
            bif.lsu_wb_data  = $urandom;
            #1;
            exp_stall = m_stall();
            exp_ready = m_ready();
            checks++; if (bif.issue_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall: cycle %0d got %b expected %b", c, bif.issue_stall, exp_stall); end
            checks++; if (bif.lsu_wb_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready: cycle %0d got %b expected %b", c, bif.lsu_wb_ready, exp_ready); end
            model_advance();
            tick();
            checks++; if (bif.rf_we !== m_we) begin errors++; $display("FAIL rnd_rf_we: cycle %0d got %b expected %b", c, bif.rf_we, m_we); end
            checks++; if (bif.rf_waddr !== m_waddr || bif.rf_wdata !== m_wdata) begin
                errors++; $display("FAIL rnd_rf_data: cycle %0d got x%0d=%h expected x%0d=%h", c, bif.rf_waddr, bif.rf_wdata, m_waddr, m_wdata); end
            checks++; if (bif.busy_mask !== m_busy) begin errors++; $display("FAIL rnd_busy: cycle %0d got %h expected %h", c, bif.busy_mask, m_busy); end
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_raw_hazard();
        test_conflict();
        test_back_pressure();
        test_zero_reg();
        test_waw();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
